generador_texto_rtc: RTL and testbench
======================================

Name: generador_texto_rtc

Overview:
Parametrised VGA text-overlay generator for the RTC controller. It renders the labels FECHA, HORA and TIMER, live BCD date, time and timer digits, a 12h/24h suffix and a blinking alarm symbol, all from an external font ROM. It adds glyph scaling, matching of the font-ROM latency, and blanking of the digit pair being edited so the user sees which field is selected. It sits between the VGA sync counter and the RGB output mux.

Parameters:
SCALE_LOG2, 1, glyph scale factor 2^SCALE_LOG2 (0..2); base cell is 8x16 pixels.
ROM_LAT, 1, font ROM read latency in cycles (1 or 2).
BLINK_FRAMES, 30, frames per blink half-period (>=1).
COL_LABEL, 3'b010, colour of label text.
COL_DIGIT, 3'b111, colour of digit text.
COL_ALARM, 3'b100, colour of the alarm symbol and of the timer digits while the alarm is active.

Ports:
CLK  in  1  pixel clock.
RESET  in  1  reset.
video_on  in  1  active-video qualifier aligned with pix_x/pix_y.
pix_x  in  10  scanner column.
pix_y  in  10  scanner row.
frame_tick  in  1  one-cycle pulse, once per frame.
fecha_bcd  in  24  {dd, mm, aa} as six BCD nibbles, MS first.
hora_bcd  in  24  {hh, mm, ss}.
timer_bcd  in  24  {hh, mm, ss}.
fmt_12h  in  1  1 = 12h display.
pm  in  1  PM flag, used when fmt_12h=1.
edit_en  in  1  edit mode active.
edit_field  in  4  pair being edited: 0..2 = dd, mm, aa; 3..5 = hh, mm, ss; 6..8 = timer hh, mm, ss.
alarm_active  in  1  alarm ringing.
rom_addr  out  11  {char[6:0], glyph_row[3:0]} to the font ROM.
font_word  in  8  ROM data, valid ROM_LAT cycles after rom_addr.
graph_rgb  out  3  pixel colour.
text_on  out  1  pixel lies inside a text cell (used by the downstream mux).

Behaviour:
- RESET: asynchronous, active-high; clock CLK.
- On RESET: graph_rgb=0, text_on=0, rom_addr=0, blink phase=0, frame counter=0, all pipeline flags cleared.
- Cell coordinates:
  - col = pix_x >> (3+S), row = pix_y >> (4+S).
  - glyph_row = (pix_y >> S)[3:0], glyph_bit = (pix_x >> S)[2:0].
- Layout, fixed in cell units for every S (cells outside the layout are off):
  - row 1, cols 2-6: "FECHA".
  - row 2, cols 2-9: dd '/' mm '/' aa.
  - row 4, cols 2-5: "HORA".
  - row 5, cols 2-9: hh ':' mm ':' ss.
  - row 5, cols 11-12: "AM"/"PM" when fmt_12h=1, else "24".
  - row 7, cols 2-6: "TIMER".
  - row 7, col 12: char 0x06 (alarm symbol).
  - row 8, cols 2-9: timer hh ':' mm ':' ss.
- Digit rendering:
  - A digit nibble d renders as 0x30+d; a nibble >9 renders as '?' (0x3F).
  - Hours are displayed as supplied; the block performs no 12/24 conversion.
- Pipeline:
  - Stage 0: char code, glyph_row, glyph_bit, colour and on-flag are computed combinationally; rom_addr is registered.
  - The bit, colour and on-flag are delayed so they meet font_word.
  - graph_rgb and text_on are registered.
  - Total latency from pix_x/pix_y to graph_rgb is ROM_LAT+2 cycles, constant, including for off pixels.
- Pixel colour:
  - Pixel on = text cell AND font_word[7-glyph_bit] AND video_on (video_on delayed identically).
  - Otherwise graph_rgb=000.
  - text_on follows cell membership regardless of font_bit.
- Blink:
  - The counter increments on frame_tick.
  - When it reaches BLINK_FRAMES-1 together with frame_tick, it clears and the phase toggles.
  - If edit_en or edit_field changes value (registered compare), the counter clears and the phase is forced to 0 in that cycle; this has priority over frame_tick.
- Edit blanking:
  - When edit_en=1, phase=1 and edit_field<=8, both digit cells of the selected pair render as space (0x20); separators are unaffected.
  - edit_field>8 blanks nothing.
- Alarm:
  - The symbol cell renders 0x06 in COL_ALARM only when alarm_active=1 and phase=0; otherwise it renders as space.
  - While alarm_active=1, timer digits use COL_ALARM.
- Colours: labels and suffix use COL_LABEL; date/time digits and separators use COL_DIGIT.
- RESET mid-frame: outputs go to 0 immediately. After release, the first ROM_LAT+2 cycles output black, then normal output resumes.

Test Plan:
- S=1, ROM_LAT=1, fecha_bcd=24'h170923, scan row 2 -> rom_addr chars in sequence 0x31, 0x37, 0x2F, 0x30, 0x39, 0x2F, 0x32, 0x33; graph_rgb=111 on glyph pixels, exactly 3 cycles after pix_x.
- hora_bcd nibble = 4'hA -> '?' (0x3F); fmt_12h=1, pm=1 -> row 5 cols 11-12 show 'P','M'; fmt_12h=0 -> '2','4'.
- BLINK_FRAMES=2, edit_en=1, edit_field=4, 8 frame_ticks -> hora minute cells alternate visible/blank every 2 frames; ':' always drawn; changing edit_field to 5 -> phase=0 immediately and the seconds cells are visible.
- alarm_active=1 -> symbol at (row 7, col 12) blinks with COL_ALARM=100 and timer digits are red; alarm_active=0 -> symbol blank.
- ROM_LAT=2, S=0 and S=2 -> latency is 4 cycles, the layout scales, and a pixel outside all cells gives graph_rgb=000, text_on=0.
- RESET asserted mid-line -> graph_rgb=0, text_on=0 asynchronously, phase=0; after release, black for ROM_LAT+2 cycles, then correct pixels; video_on=0 always gives black.

Source files
------------

// File: rtl/generador_texto_rtc.sv
// Text overlay for the RTC VGA display: date, time and timer fields with labels,
// edit-field blinking and alarm symbol, fed through an external font ROM.
module generador_texto_rtc #(
  parameter int         SCALE_LOG2   = 1,
  parameter int         ROM_LAT      = 1,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [2:0] COL_LABEL    = 3'b010,
  parameter logic [2:0] COL_DIGIT    = 3'b111,
  parameter logic [2:0] COL_ALARM    = 3'b100
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        video_on,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        frame_tick,
  input  logic [23:0] fecha_bcd,
  input  logic [23:0] hora_bcd,
  input  logic [23:0] timer_bcd,
  input  logic        fmt_12h,
  input  logic        pm,
  input  logic        edit_en,
  input  logic [3:0]  edit_field,
  input  logic        alarm_active,
  output logic [10:0] rom_addr,
  input  logic [7:0]  font_word,
  output logic [2:0]  graph_rgb,
  output logic        text_on
);

  localparam int DLY = ROM_LAT + 1;
  localparam int CW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] r_blink_cnt;
  logic          r_phase;
  logic          r_edit_en_q;
  logic [3:0]    r_edit_field_q;
  logic          w_edit_chg;

  assign w_edit_chg = (edit_en != r_edit_en_q) || (edit_field != r_edit_field_q);

  // Any change of the edit selection restarts the blink so the new field shows at once
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_blink_cnt    <= '0;
      r_phase        <= 1'b0;
      r_edit_en_q    <= 1'b0;
      r_edit_field_q <= 4'd0;
    end else begin
      r_edit_en_q    <= edit_en;
      r_edit_field_q <= edit_field;
      if (w_edit_chg) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
      end else if (frame_tick) begin
        if (r_blink_cnt == CW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  logic [9:0]  w_col, w_row;
  logic [3:0]  w_glyph_row;
  logic [2:0]  w_glyph_bit;

  assign w_col       = pix_x >> (3 + SCALE_LOG2);
  assign w_row       = pix_y >> (4 + SCALE_LOG2);
  assign w_glyph_row = 4'(pix_y >> SCALE_LOG2);
  assign w_glyph_bit = 3'(pix_x >> SCALE_LOG2);

  function automatic logic [6:0] f_digit(input logic [3:0] d);
    return (d > 4'd9) ? 7'h3F : {3'b011, d};
  endfunction

  logic [6:0]  w_char;
  logic [2:0]  w_color;
  logic        w_cell;
  logic [23:0] w_bcd;
  logic [3:0]  w_base, w_pair, w_nib;
  logic [6:0]  w_sep;
  logic [2:0]  w_dig_col;
  logic        w_is_dig, w_blank;

  always_comb begin
    w_char    = 7'h00;
    w_color   = 3'b000;
    w_cell    = 1'b0;
    w_bcd     = fecha_bcd;
    w_base    = 4'd0;
    w_sep     = 7'h2F;
    w_dig_col = COL_DIGIT;
    w_nib     = 4'd0;
    w_pair    = 4'd0;
    w_is_dig  = 1'b1;

    case (w_row)
      10'd5: begin
        w_bcd  = hora_bcd;
        w_base = 4'd3;
        w_sep  = 7'h3A;
      end
      10'd8: begin
        w_bcd  = timer_bcd;
        w_base = 4'd6;
        w_sep  = 7'h3A;
        if (alarm_active) w_dig_col = COL_ALARM;
      end
      default: ;
    endcase

    case (w_col)
      10'd2:   w_nib = w_bcd[23:20];
      10'd3:   w_nib = w_bcd[19:16];
      10'd5:   begin w_nib = w_bcd[15:12]; w_pair = 4'd1; end
      10'd6:   begin w_nib = w_bcd[11:8];  w_pair = 4'd1; end
      10'd8:   begin w_nib = w_bcd[7:4];   w_pair = 4'd2; end
      10'd9:   begin w_nib = w_bcd[3:0];   w_pair = 4'd2; end
      default: w_is_dig = 1'b0;
    endcase

    w_blank = edit_en && r_phase && (edit_field == (w_base + w_pair));

    case (w_row)
      10'd1: begin
        w_color = COL_LABEL;
        w_cell  = 1'b1;
        case (w_col)
          10'd2:   w_char = 7'h46;
          10'd3:   w_char = 7'h45;
          10'd4:   w_char = 7'h43;
          10'd5:   w_char = 7'h48;
          10'd6:   w_char = 7'h41;
          default: w_cell = 1'b0;
        endcase
      end
      10'd4: begin
        w_color = COL_LABEL;
        w_cell  = 1'b1;
        case (w_col)
          10'd2:   w_char = 7'h48;
          10'd3:   w_char = 7'h4F;
          10'd4:   w_char = 7'h52;
          10'd5:   w_char = 7'h41;
          default: w_cell = 1'b0;
        endcase
      end
      10'd7: begin
        w_color = COL_LABEL;
        w_cell  = 1'b1;
        case (w_col)
          10'd2:   w_char = 7'h54;
          10'd3:   w_char = 7'h49;
          10'd4:   w_char = 7'h4D;
          10'd5:   w_char = 7'h45;
          10'd6:   w_char = 7'h52;
          10'd12: begin
            w_color = COL_ALARM;
            w_char  = (alarm_active && !r_phase) ? 7'h06 : 7'h20;
          end
          default: w_cell = 1'b0;
        endcase
      end
      10'd2, 10'd5, 10'd8: begin
        if (w_is_dig) begin
          w_cell  = 1'b1;
          w_color = w_dig_col;
          w_char  = w_blank ? 7'h20 : f_digit(w_nib);
        end else if (w_col == 10'd4 || w_col == 10'd7) begin
          w_cell  = 1'b1;
          w_color = COL_DIGIT;
          w_char  = w_sep;
        end else if (w_row == 10'd5 && (w_col == 10'd11 || w_col == 10'd12)) begin
          w_cell  = 1'b1;
          w_color = COL_LABEL;
          if (!fmt_12h)              w_char = (w_col == 10'd11) ? 7'h32 : 7'h34;
          else if (w_col == 10'd11)  w_char = pm ? 7'h50 : 7'h41;
          else                       w_char = 7'h4D;
        end
      end
      default: ;
    endcase
  end

  // Per-pixel attributes ride alongside the ROM access so they meet font_word
  logic [DLY-1:0] r_on_d, r_vid_d;
  logic [2:0]     r_bit_d [DLY];
  logic [2:0]     r_rgb_d [DLY];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rom_addr  <= '0;
      r_on_d    <= '0;
      r_vid_d   <= '0;
      for (int i = 0; i < DLY; i++) begin
        r_bit_d[i] <= '0;
        r_rgb_d[i] <= '0;
      end
      graph_rgb <= 3'b000;
      text_on   <= 1'b0;
    end else begin
      rom_addr   <= {w_char, w_glyph_row};
      r_on_d[0]  <= w_cell;
      r_vid_d[0] <= video_on;
      r_bit_d[0] <= w_glyph_bit;
      r_rgb_d[0] <= w_color;
      for (int i = 1; i < DLY; i++) begin
        r_on_d[i]  <= r_on_d[i-1];
        r_vid_d[i] <= r_vid_d[i-1];
        r_bit_d[i] <= r_bit_d[i-1];
        r_rgb_d[i] <= r_rgb_d[i-1];
      end
      graph_rgb <= (r_on_d[DLY-1] && r_vid_d[DLY-1] && font_word[3'd7 - r_bit_d[DLY-1]])
                   ? r_rgb_d[DLY-1] : 3'b000;
      text_on   <= r_on_d[DLY-1];
    end
  end

endmodule

// File: tb/tb_generador_texto_rtc.sv
// Bench for generador_texto_rtc: three scale/latency variants share one stimulus
// stream and are compared each cycle against a string/arithmetic screen model.
module tb_generador_texto_rtc;

  logic        CLK = 1'b0, RESET = 1'b1, video_on = 1'b1, frame_tick = 1'b0;
  logic        fmt_12h = 1'b0, pm = 1'b0, edit_en = 1'b0, alarm_active = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic [23:0] fecha_bcd = '0, hora_bcd = '0, timer_bcd = '0;
  logic [3:0]  edit_field = '0;
  logic [10:0] addr_o [3];
  logic [7:0]  font_o [3];
  logic [7:0]  font_p1, font_p2;
  logic [2:0]  rgb_o  [3];
  logic        ton_o  [3];

  int n_assert = 0, n_fail = 0, tb_ticks = 0, cyc = 0;

  typedef struct {
    int d; logic [2:0] er, orr; logic et, ot; logic [10:0] ea, oa; logic av;
  } chk_t;
  chk_t cq[$];

  logic [2:0]  h_rgb  [3][8];
  logic        h_ton  [3][8];
  logic [10:0] h_addr [3][8];
  logic        h_av   [3][8];

  generador_texto_rtc #(.SCALE_LOG2(1), .ROM_LAT(1), .BLINK_FRAMES(2)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .frame_tick(frame_tick), .fecha_bcd(fecha_bcd), .hora_bcd(hora_bcd), .timer_bcd(timer_bcd),
    .fmt_12h(fmt_12h), .pm(pm), .edit_en(edit_en), .edit_field(edit_field),
    .alarm_active(alarm_active), .rom_addr(addr_o[0]), .font_word(font_o[0]),
    .graph_rgb(rgb_o[0]), .text_on(ton_o[0]));

  generador_texto_rtc #(.SCALE_LOG2(0), .ROM_LAT(2), .BLINK_FRAMES(2)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .frame_tick(frame_tick), .fecha_bcd(fecha_bcd), .hora_bcd(hora_bcd), .timer_bcd(timer_bcd),
    .fmt_12h(fmt_12h), .pm(pm), .edit_en(edit_en), .edit_field(edit_field),
    .alarm_active(alarm_active), .rom_addr(addr_o[1]), .font_word(font_o[1]),
    .graph_rgb(rgb_o[1]), .text_on(ton_o[1]));

  generador_texto_rtc #(.SCALE_LOG2(2), .ROM_LAT(2), .BLINK_FRAMES(2)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .frame_tick(frame_tick), .fecha_bcd(fecha_bcd), .hora_bcd(hora_bcd), .timer_bcd(timer_bcd),
    .fmt_12h(fmt_12h), .pm(pm), .edit_en(edit_en), .edit_field(edit_field),
    .alarm_active(alarm_active), .rom_addr(addr_o[2]), .font_word(font_o[2]),
    .graph_rgb(rgb_o[2]), .text_on(ton_o[2]));

  always #5 CLK = ~CLK;

  function automatic logic [7:0] font_fn(input logic [10:0] a);
    return a[7:0] ^ {a[2:0], a[10:6]} ^ 8'hA5;
  endfunction

  always @(posedge CLK) begin
    font_o[0] <= font_fn(addr_o[0]);
    font_p1   <= font_fn(addr_o[1]);
    font_o[1] <= font_p1;
    font_p2   <= font_fn(addr_o[2]);
    font_o[2] <= font_p2;
  end

  function automatic int s_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 2;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // Screen model: what should appear at (x,y) for scale 2^s, from the layout rules
  function automatic void model(input int s, input int x, input int y,
                                output logic [2:0] rgb, output logic ton, output logic [10:0] addr);
    int col, row, gr, gb, p, pair, nib;
    logic [7:0] ch, f;
    logic [2:0] c;
    logic on, phs;
    logic [23:0] v;
    string lbl;
    col = x >> (3 + s);
    row = y >> (4 + s);
    gr  = (y >> s) % 16;
    gb  = (x >> s) % 8;
    phs = ((tb_ticks / 2) % 2) == 1;
    ch = 8'h00; c = 3'b000; on = 1'b0; lbl = "";
    if (row == 1) lbl = "FECHA"; else if (row == 4) lbl = "HORA"; else if (row == 7) lbl = "TIMER";
    if (lbl.len() > 0 && col >= 2 && col - 2 < lbl.len()) begin
      on = 1'b1; c = 3'b010; ch = lbl[col-2];
    end
    if (row == 7 && col == 12) begin
      on = 1'b1; c = 3'b100; ch = (alarm_active && !phs) ? 8'h06 : 8'h20;
    end
    if ((row == 2 || row == 5 || row == 8) && col >= 2 && col <= 9) begin
      if (row == 2) v = fecha_bcd; else if (row == 5) v = hora_bcd; else v = timer_bcd;
      p = col - 2;
      on = 1'b1;
      if (p % 3 == 2) begin
        c = 3'b111; ch = (row == 2) ? 8'h2F : 8'h3A;
      end else begin
        pair = p / 3;
        nib  = int'((v >> (20 - 8 * pair - 4 * (p % 3))) & 24'hF);
        ch   = (nib > 9) ? 8'h3F : 8'h30 + 8'(nib);
        c    = (row == 8 && alarm_active) ? 3'b100 : 3'b111;
        if (edit_en && phs && int'(edit_field) == (row - 2) + pair) ch = 8'h20;
      end
    end
    if (row == 5 && (col == 11 || col == 12)) begin
      on = 1'b1; c = 3'b010;
      if (!fmt_12h) lbl = "24"; else if (pm) lbl = "PM"; else lbl = "AM";
      ch = lbl[col-11];
    end
    addr = {ch[6:0], 4'(gr)};
    f    = font_fn(addr);
    rgb  = (on && video_on && f[7-gb]) ? c : 3'b000;
    ton  = on;
  endfunction

  task automatic clear_hist();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 8; k++) begin
        h_rgb[d][k] = '0; h_ton[d][k] = 1'b0; h_addr[d][k] = '0; h_av[d][k] = 1'b0;
      end
  endtask

  // Drive one pixel for one cycle; record each variant's matured expectation vs output
  task automatic step_px(input int x, input int y);
    logic [2:0] r; logic t; logic [10:0] a; chk_t c; int ke, ka;
    pix_x = 10'(x); pix_y = 10'(y);
    for (int d = 0; d < 3; d++) begin
      if (RESET) begin r = '0; t = 1'b0; a = '0; end
      else model(s_of(d), x, y, r, t, a);
      h_rgb[d][cyc%8] = r; h_ton[d][cyc%8] = t; h_addr[d][cyc%8] = a; h_av[d][cyc%8] = t;
    end
    @(posedge CLK); #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      ke = (cyc + 8 - lat_of(d) - 2) % 8;
      ka = (cyc + 7) % 8;
      c.d = d; c.er = h_rgb[d][ke]; c.orr = rgb_o[d]; c.et = h_ton[d][ke]; c.ot = ton_o[d];
      c.ea = h_addr[d][ka]; c.oa = addr_o[d]; c.av = h_av[d][ka];
      cq.push_back(c);
    end
  endtask

  task automatic rnd_px(input int row);
    int s, x, y;
    s = int'($urandom_range(0, 2));
    if (row < 0) begin
      x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023));
    end else begin
      x = (int'($urandom_range(0, 14)) << (3 + s)) + int'($urandom_range(0, (8 << s) - 1));
      y = (row << (4 + s)) + int'($urandom_range(0, (16 << s) - 1));
    end
    step_px(x, y);
  endtask

  task automatic pulse_frame();
    frame_tick = 1'b1;
    step_px(0, 0);
    frame_tick = 1'b0;
    tb_ticks++;
  endtask

  task automatic set_edit(input logic en, input logic [3:0] f);
    if (en != edit_en || f != edit_field) begin
      edit_en = en; edit_field = f;
      step_px(0, 0);
      tb_ticks = 0;
    end
  endtask

  task automatic test_reset();
    clear_hist();
    for (int i = 0; i < 4; i++) rnd_px(2);
    for (int d = 0; d < 3; d++) begin
      n_assert++;
      if (rgb_o[d] !== 3'b000 || ton_o[d] !== 1'b0 || addr_o[d] !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d got rgb=%b ton=%b addr=%h want 0/0/0", d, rgb_o[d], ton_o[d], addr_o[d]);
      end
    end
    RESET = 1'b0;
    for (int i = 0; i < 12; i++) rnd_px(1);
    while (cq.size() > 0) begin
      chk_t c; c = cq.pop_front();
      n_assert++; if (c.orr !== c.er) begin n_fail++; $display("FAIL reset_rgb dut%0d got %b want %b", c.d, c.orr, c.er); end
      n_assert++; if (c.ot !== c.et) begin n_fail++; $display("FAIL reset_text_on dut%0d got %b want %b", c.d, c.ot, c.et); end
      if (c.av) begin n_assert++; if (c.oa !== c.ea) begin n_fail++; $display("FAIL reset_addr dut%0d got %h want %h", c.d, c.oa, c.ea); end end
    end
  endtask

  task automatic test_date_row();
    fecha_bcd = 24'h170923;
    for (int gr = 3; gr < 16; gr += 4)
      for (int x = 0; x < 192; x++) step_px(x, 64 + gr * 2);
    while (cq.size() > 0) begin
      chk_t c; c = cq.pop_front();
      n_assert++; if (c.orr !== c.er) begin n_fail++; $display("FAIL date_rgb dut%0d got %b want %b", c.d, c.orr, c.er); end
      n_assert++; if (c.ot !== c.et) begin n_fail++; $display("FAIL date_text_on dut%0d got %b want %b", c.d, c.ot, c.et); end
      if (c.av) begin n_assert++; if (c.oa !== c.ea) begin n_fail++; $display("FAIL date_addr dut%0d got %h want %h", c.d, c.oa, c.ea); end end
    end
  endtask

  task automatic test_time_suffix();
    hora_bcd = 24'h12A459;
    fmt_12h = 1'b1; pm = 1'b1;
    for (int i = 0; i < 150; i++) rnd_px(5);
    pm = 1'b0;
    for (int i = 0; i < 100; i++) rnd_px(5);
    fmt_12h = 1'b0;
    for (int i = 0; i < 150; i++) rnd_px(5);
    while (cq.size() > 0) begin
      chk_t c; c = cq.pop_front();
      n_assert++; if (c.orr !== c.er) begin n_fail++; $display("FAIL time_rgb dut%0d got %b want %b", c.d, c.orr, c.er); end
      n_assert++; if (c.ot !== c.et) begin n_fail++; $display("FAIL time_text_on dut%0d got %b want %b", c.d, c.ot, c.et); end
      if (c.av) begin n_assert++; if (c.oa !== c.ea) begin n_fail++; $display("FAIL time_addr dut%0d got %h want %h", c.d, c.oa, c.ea); end end
    end
  endtask

  task automatic test_edit_blink();
    hora_bcd = 24'h093547;
    set_edit(1'b1, 4'd4);
    for (int f = 0; f < 8; f++) begin
      pulse_frame();
      for (int i = 0; i < 40; i++) rnd_px(5);
    end
    pulse_frame();
    set_edit(1'b1, 4'd5);
    for (int i = 0; i < 60; i++) rnd_px(5);
    for (int f = 0; f < 3; f++) begin
      pulse_frame();
      for (int i = 0; i < 30; i++) rnd_px(5);
    end
    set_edit(1'b1, 4'd11);
    for (int i = 0; i < 30; i++) rnd_px(5);
    set_edit(1'b0, 4'd0);
    while (cq.size() > 0) begin
      chk_t c; c = cq.pop_front();
      n_assert++; if (c.orr !== c.er) begin n_fail++; $display("FAIL blink_rgb dut%0d got %b want %b", c.d, c.orr, c.er); end
      n_assert++; if (c.ot !== c.et) begin n_fail++; $display("FAIL blink_text_on dut%0d got %b want %b", c.d, c.ot, c.et); end
      if (c.av) begin n_assert++; if (c.oa !== c.ea) begin n_fail++; $display("FAIL blink_addr dut%0d got %h want %h", c.d, c.oa, c.ea); end end
    end
  endtask

  task automatic test_alarm();
    timer_bcd = 24'h010203;
    alarm_active = 1'b1;
    for (int f = 0; f < 6; f++) begin
      pulse_frame();
      for (int i = 0; i < 30; i++) rnd_px((i % 2 == 0) ? 7 : 8);
    end
    alarm_active = 1'b0;
    for (int i = 0; i < 40; i++) rnd_px((i % 2 == 0) ? 7 : 8);
    while (cq.size() > 0) begin
      chk_t c; c = cq.pop_front();
      n_assert++; if (c.orr !== c.er) begin n_fail++; $display("FAIL alarm_rgb dut%0d got %b want %b", c.d, c.orr, c.er); end
      n_assert++; if (c.ot !== c.et) begin n_fail++; $display("FAIL alarm_text_on dut%0d got %b want %b", c.d, c.ot, c.et); end
      if (c.av) begin n_assert++; if (c.oa !== c.ea) begin n_fail++; $display("FAIL alarm_addr dut%0d got %h want %h", c.d, c.oa, c.ea); end end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) begin
        fecha_bcd = 24'($urandom); hora_bcd = 24'($urandom); timer_bcd = 24'($urandom);
        fmt_12h = 1'($urandom); pm = 1'($urandom); alarm_active = 1'($urandom);
        set_edit(1'($urandom), 4'($urandom_range(0, 10)));
      end
      if (i % 17 == 0) pulse_frame();
      rnd_px((i % 5 == 0) ? -1 : int'($urandom_range(0, 10)));
    end
    while (cq.size() > 0) begin
      chk_t c; c = cq.pop_front();
      n_assert++; if (c.orr !== c.er) begin n_fail++; $display("FAIL random_rgb dut%0d got %b want %b", c.d, c.orr, c.er); end
      n_assert++; if (c.ot !== c.et) begin n_fail++; $display("FAIL random_text_on dut%0d got %b want %b", c.d, c.ot, c.et); end
      if (c.av) begin n_assert++; if (c.oa !== c.ea) begin n_fail++; $display("FAIL random_addr dut%0d got %h want %h", c.d, c.oa, c.ea); end end
    end
  endtask

  task automatic test_reset_midline();
    fecha_bcd = 24'h281299;
    alarm_active = 1'b0;
    set_edit(1'b1, 4'd0);
    pulse_frame();
    pulse_frame();
    for (int i = 0; i < 40; i++) rnd_px(2);
    #3;
    RESET = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_assert++;
      if (rgb_o[d] !== 3'b000 || ton_o[d] !== 1'b0 || addr_o[d] !== 11'd0) begin
        n_fail++;
        $display("FAIL midline_reset dut%0d got rgb=%b ton=%b addr=%h want 0/0/0", d, rgb_o[d], ton_o[d], addr_o[d]);
      end
    end
    clear_hist();
    tb_ticks = 0;
    for (int i = 0; i < 3; i++) rnd_px(2);
    RESET = 1'b0;
    for (int i = 0; i < 60; i++) rnd_px(2);
    while (cq.size() > 0) begin
      chk_t c; c = cq.pop_front();
      n_assert++; if (c.orr !== c.er) begin n_fail++; $display("FAIL midline_rgb dut%0d got %b want %b", c.d, c.orr, c.er); end
      n_assert++; if (c.ot !== c.et) begin n_fail++; $display("FAIL midline_text_on dut%0d got %b want %b", c.d, c.ot, c.et); end
      if (c.av) begin n_assert++; if (c.oa !== c.ea) begin n_fail++; $display("FAIL midline_addr dut%0d got %h want %h", c.d, c.oa, c.ea); end end
    end
  endtask

  task automatic test_video_off();
    video_on = 1'b0;
    for (int i = 0; i < 100; i++) rnd_px(int'($urandom_range(0, 9)));
    video_on = 1'b1;
    for (int i = 0; i < 30; i++) rnd_px(int'($urandom_range(0, 9)));
    while (cq.size() > 0) begin
      chk_t c; c = cq.pop_front();
      n_assert++; if (c.orr !== c.er) begin n_fail++; $display("FAIL video_rgb dut%0d got %b want %b", c.d, c.orr, c.er); end
      n_assert++; if (c.ot !== c.et) begin n_fail++; $display("FAIL video_text_on dut%0d got %b want %b", c.d, c.ot, c.et); end
      if (c.av) begin n_assert++; if (c.oa !== c.ea) begin n_fail++; $display("FAIL video_addr dut%0d got %h want %h", c.d, c.oa, c.ea); end end
    end
  endtask

  initial begin
    test_reset();
    test_date_row();
    test_time_suffix();
    test_edit_blink();
    test_alarm();
    test_random();
    test_reset_midline();
    test_video_off();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
